fetch_stage: RTL

- Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the PC register and the IF/ID pipeline register.
- Consumes the hazard unit's PCWrite/Stall/NoOp-style controls and the ID-stage branch redirect.
- Talks to a variable-latency instruction memory through a req/ack handshake.
- Buffers a returned instruction while ID is stalled and discards in-flight fetches on flush.

---
 rtl/fetch_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of a 5-stage RISC-V pipeline.
//   Owns the PC and the IF/ID pipeline register. It fetches from a
//   variable-latency instruction memory using a req/ack handshake, buffers a
//   returned instruction in a skid register while ID is stalled, and drains
//   any in-flight fetch after a branch redirect without abandoning it.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-low reset
//   PCWrite_i, Stall_i  hazard-unit controls (hold = Stall_i | ~PCWrite_i)
//   Flush_i             branch taken in ID: squash IF/ID, redirect PC
//   BranchAddr_i        redirect target, valid with Flush_i
//   imem_req_o          fetch request
//   imem_addr_o         fetch address, stable until acknowledged
//   imem_ack_i          instruction returned this cycle
//   imem_data_i         returned instruction
//   pc_o, instr_o       IF/ID PC and instruction
//   valid_o             IF/ID holds a real instruction
module fetch_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            PCWrite_i,
  input  logic            Stall_i,
  input  logic            Flush_i,
  input  logic [XLEN-1:0] BranchAddr_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_data_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic              started_q;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic              skid_vld_q, skid_vld_d;
  logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
  logic [31:0]       ifid_instr_q, ifid_instr_d;
  logic              ifid_vld_q, ifid_vld_d;

  logic hold;
  logic ack_v;

  // No request during reset; the first one goes out on the first edge after
  // reset is released. HOLD never requests because the skid is already full.
  assign imem_req_o  = started_q & (state_q != S_HOLD);
  assign imem_addr_o = pc_q;

  assign hold  = Stall_i | ~PCWrite_i;
  assign ack_v = imem_ack_i & imem_req_o;  // stray acks are ignored

  assign pc_o    = ifid_pc_q;
  assign instr_o = ifid_instr_q;
  assign valid_o = ifid_vld_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_vld_d   = skid_vld_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_vld_d   = ifid_vld_q;

    if (Flush_i) begin
      // Flush beats hold: IF/ID is squashed even when ID is stalled.
      ifid_pc_d    = BranchAddr_i;
      ifid_instr_d = NOP_INSTR;
      ifid_vld_d   = 1'b0;
      skid_vld_d   = 1'b0;
      skid_pc_d    = '0;
      skid_instr_d = NOP_INSTR;
    end

    case (state_q)
      S_FETCH: begin
        if (Flush_i) begin
          if (ack_v) begin
            pc_d = BranchAddr_i;  // returned data is dropped
          end else begin
            // The outstanding request must complete before redirecting.
            tgt_d   = BranchAddr_i;
            state_d = S_DRAIN;
          end
        end else if (ack_v) begin
          if (hold) begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem_data_i;
            skid_vld_d   = 1'b1;
            state_d      = S_HOLD;
          end else begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_data_i;
            ifid_vld_d   = 1'b1;
            pc_d         = pc_q + PC_INC;
          end
        end else if (!hold) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = NOP_INSTR;
          ifid_vld_d   = 1'b0;
        end
      end

      S_HOLD: begin
        if (Flush_i) begin
          pc_d    = BranchAddr_i;
          state_d = S_FETCH;
        end else if (!hold) begin
          ifid_pc_d    = skid_pc_q;
          ifid_instr_d = skid_instr_q;
          ifid_vld_d   = skid_vld_q;
          skid_vld_d   = 1'b0;
          pc_d         = skid_pc_q + PC_INC;
          state_d      = S_FETCH;
        end
      end

      S_DRAIN: begin
        // A newer flush replaces the pending target, even on the ack cycle.
        if (ack_v) begin
          pc_d    = Flush_i ? BranchAddr_i : tgt_q;
          state_d = S_FETCH;
        end else if (Flush_i) begin
          tgt_d = BranchAddr_i;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_FETCH;
      pc_q         <= XLEN'(RESET_PC);
      tgt_q        <= '0;
      started_q    <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_vld_q   <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      started_q    <= 1'b1;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_vld_q   <= skid_vld_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

endmodule
